mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-array memory target with a fixed number of wait states and a one-cycle ready pulse.
// Defining MEM_RESPONDER_ADDR_CHECK_EN adds fault checking for misaligned or out-of-range addresses.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    we_q, we_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mem_we;
    logic                    access_ok;

    // Array contents are deliberately left out of reset.
    logic [31:0] mem [2**DEPTH_LOG2];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (state_q == IDLE && req)
            fault_d = (|adr[1:0]) || (|adr[31:DEPTH_LOG2+2]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign access_ok = !fault_q;
    assign err       = (state_q == DONE) && fault_q;
`else
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, adr[31:DEPTH_LOG2+2], adr[1:0]};
    assign access_ok       = 1'b1;
    assign err             = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = adr[DEPTH_LOG2+1:2];
                    we_d    = memwrite;
                    wdata_d = writedata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!access_ok) begin
                        rdata_d = 32'h0;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The write strobe only exists in BUSY, so a reset mid-access cancels it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign readdata = rdata_q;
    assign ready    = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req, req0;
    logic        memwrite;
    logic [31:0] adr, writedata;
    logic [31:0] readdata, readdata0;
    logic        ready, ready0, busy, busy0, err, err0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .adr(adr),
        .writedata(writedata), .readdata(readdata), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .memwrite(memwrite), .adr(adr),
        .writedata(writedata), .readdata(readdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on the selected instance; returns edges from acceptance to ready (-1 on timeout).
    task automatic access(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, output int edges, output logic [31:0] rd,
                          output logic e, output logic ready_after);
        memwrite = we; adr = a; writedata = d;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; req0 = 1'b0;
        if (scramble) begin
            adr = 32'h0; writedata = 32'h0; memwrite = 1'b0;
        end
        edges = -1;
        rd = 32'hx; e = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (sel ? ready0 : ready) begin
                edges = i + 1;
                rd = sel ? readdata0 : readdata;
                e  = sel ? err0 : err;
                break;
            end
        end
        @(posedge clk); #1;
        ready_after = sel ? ready0 : ready;
        $display("access sel=%0d we=%0d adr=%h wd=%h -> edges=%0d rd=%h err=%b", sel, we, a, d, edges, rd, e);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ready, busy, err, readdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b err=%b rd=%h, want all 0", ready, busy, err, readdata);
        end
        n_cmp++;
        if ({ready0, busy0, err0, readdata0} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outputs0: got rdy=%b busy=%b err=%b rd=%h, want all 0", ready0, busy0, err0, readdata0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int edges; logic [31:0] rd; logic e, ra;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 4 || e !== 1'b0 || ra !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_10: got edges=%0d err=%b ready_after=%b rd=%h, want 4 0 0 deadbeef", edges, e, ra, rd);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 4 || e !== 1'b0 || ra !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rd_10: got edges=%0d err=%b ready_after=%b rd=%h, want 4 0 0 deadbeef", edges, e, ra, rd);
        end
        n_cmp++;
        if (readdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rd_hold: got %h, want deadbeef", readdata);
        end
    endtask

    task automatic test_wait0();
        int edges; logic [31:0] rd; logic e, ra;
        access(1'b1, 1'b1, 32'h0, 32'h1, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 2 || rd !== 32'h1) begin
            n_bad++;
            $display("FAIL w0_wr: got edges=%0d rd=%h, want 2 00000001", edges, rd);
        end
        access(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 2 || rd !== 32'h1 || e !== 1'b0 || ra !== 1'b0) begin
            n_bad++;
            $display("FAIL w0_rd: got edges=%0d rd=%h err=%b ready_after=%b, want 2 00000001 0 0", edges, rd, e, ra);
        end
    endtask

    task automatic test_inflight();
        int edges; logic [31:0] rd; logic e, ra;
        access(1'b0, 1'b1, 32'h0, 32'h11110000, 1'b0, edges, rd, e, ra);
        memwrite = 1'b1; adr = 32'h20; writedata = 32'h12345678; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; adr = 32'h0; writedata = 32'h0; memwrite = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL inflight_busy: got %b, want 1", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h12345678) begin
            n_bad++;
            $display("FAIL inflight_20: got %h, want 12345678", rd);
        end
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h11110000) begin
            n_bad++;
            $display("FAIL inflight_0: got %h, want 11110000", rd);
        end
    endtask

    task automatic test_reset_abort();
        int edges; logic [31:0] rd; logic e, ra;
        int seen = 0;
        access(1'b0, 1'b1, 32'h40, 32'h5, 1'b0, edges, rd, e, ra);
        memwrite = 1'b1; adr = 32'h40; writedata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, err, readdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL abort_outputs: got rdy=%b busy=%b err=%b rd=%h, want all 0", ready, busy, err, readdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_ready: got %0d ready cycles, want 0", seen);
        end
        access(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 4 || rd !== 32'h5) begin
            n_bad++;
            $display("FAIL abort_rd_40: got edges=%0d rd=%h, want 4 00000005", edges, rd);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        memwrite = 1'b0; adr = 32'h10; req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (ready && first < 0) first = i;
            else if (ready && second < 0) second = i;
        end
        req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (first !== 4 || second !== 9) begin
            n_bad++;
            $display("FAIL b2b_timing: got ready at edges %0d,%0d, want 4,9", first, second);
        end
    endtask

    task automatic test_addr();
        int edges; logic [31:0] rd; logic e, ra;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
        access(1'b0, 1'b1, 32'h41, 32'hFFFFFFFF, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (edges !== 4 || e !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL fault_41: got edges=%0d err=%b rd=%h, want 4 1 00000000", edges, e, rd);
        end
        access(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h5 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_41_unchanged: got rd=%h err=%b, want 00000005 0", rd, e);
        end
        access(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL fault_400: got err=%b rd=%h, want 1 00000000", e, rd);
        end
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h11110000) begin
            n_bad++;
            $display("FAIL fault_400_unchanged: got %h, want 11110000", rd);
        end
`else
        access(1'b0, 1'b0, 32'h400, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h11110000 || e !== 1'b0 || edges !== 4) begin
            n_bad++;
            $display("FAIL alias_400: got rd=%h err=%b edges=%0d, want 11110000 0 4", rd, e, edges);
        end
        access(1'b0, 1'b0, 32'h43, 32'h0, 1'b0, edges, rd, e, ra);
        n_cmp++;
        if (rd !== 32'h5 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL alias_43: got rd=%h err=%b, want 00000005 0", rd, e);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; req0 = 1'b0;
        memwrite = 1'b0; adr = 32'h0; writedata = 32'h0;
        test_reset();
        test_write_read();
        test_wait0();
        test_inflight();
        test_reset_abort();
        test_back_to_back();
        test_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
